// File: rtl/axis_burst_packer_pkg.sv
// Shared types and constants for the AXI-Stream burst packer.
package axis_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int STS_W = 32;

endpackage

// File: rtl/axis_burst_packer_if.sv
// AXI-Stream channel bundle (tdata/tvalid/tready/tlast) with master and slave views.
interface axis_burst_packer_if #(
  parameter int AXIS_TDATA_WIDTH = 32
);

  logic [AXIS_TDATA_WIDTH-1:0] tdata;
  logic                        tvalid;
  logic                        tready;
  logic                        tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_burst_packer.sv
// Releases FIFO data only in whole bursts of cfg_data beats and frames each burst with tlast.
// Optional short flush bursts after an idle timeout: define AXIS_BURST_TIMEOUT_EN.
module axis_burst_packer
  import axis_burst_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [CNTR_WIDTH-1:0] cfg_data,
  input  logic [CNTR_WIDTH-1:0] fifo_count,
`ifdef AXIS_BURST_TIMEOUT_EN
  input  logic [31:0]           cfg_timeout,
`endif
  output logic [STS_W-1:0]      sts_data,
  axis_burst_packer_if.slave    s_axis,
  axis_burst_packer_if.master   m_axis
);

  state_t                  state, state_nxt;
  logic [CNTR_WIDTH-1:0]   beat_cnt;
  logic [CNTR_WIDTH-1:0]   len_q;
  logic [CNTR_WIDTH-1:0]   len_nxt;
  logic [STS_W-1:0]        sts_q;
  logic                    full_hit;
  logic                    start;
  logic                    in_burst;
  logic                    hs;
  logic                    last;

  assign in_burst = (state == BURST);
  assign full_hit = (cfg_data != '0) && (fifo_count >= cfg_data);
  assign hs       = in_burst && s_axis.tvalid && m_axis.tready;
  assign last     = in_burst && (beat_cnt == len_q - CNTR_WIDTH'(1));

`ifdef AXIS_BURST_TIMEOUT_EN
  logic [31:0] timer_q;
  logic        timeout_hit;

  // Flush whatever is buffered once a partial fill has sat idle long enough.
  assign timeout_hit = (cfg_timeout != '0) && (timer_q >= cfg_timeout) &&
                       (fifo_count != '0) && (fifo_count < cfg_data);
  assign start       = full_hit || timeout_hit;
  assign len_nxt     = full_hit ? cfg_data : fifo_count;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      timer_q <= '0;
    end else if ((state != IDLE) || start || (fifo_count == '0)) begin
      timer_q <= '0;
    end else if (fifo_count < cfg_data) begin
      timer_q <= timer_q + 32'd1;
    end
  end
`else
  assign start   = full_hit;
  assign len_nxt = cfg_data;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BURST;
      BURST:   if (hs && last) state_nxt = GAP;
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_q    <= '0;
      sts_q    <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len_nxt;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          if (hs) begin
            beat_cnt <= beat_cnt + CNTR_WIDTH'(1);
            if (last) sts_q <= sts_q + STS_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Stream is gated everywhere except inside an open burst.
  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tvalid = in_burst && s_axis.tvalid;
  assign s_axis.tready = in_burst && m_axis.tready;
  assign m_axis.tlast  = last;
  assign sts_data      = sts_q;

endmodule

// File: tb/tb_axis_burst_packer.sv
// Self-checking bench for axis_burst_packer: per-cycle reference model plus directed scenarios.
module tb_axis_burst_packer;

  localparam int DW = 32;
  localparam int CW = 10;

  logic          aclk;
  logic          aresetn;
  logic [CW-1:0] cfg_data;
  logic [CW-1:0] fifo_count;
  logic [31:0]   cfg_timeout;
  logic [31:0]   sts_data;

  axis_burst_packer_if #(.AXIS_TDATA_WIDTH(DW)) s_axis ();
  axis_burst_packer_if #(.AXIS_TDATA_WIDTH(DW)) m_axis ();

  axis_burst_packer #(.AXIS_TDATA_WIDTH(DW), .CNTR_WIDTH(CW)) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .cfg_data   (cfg_data),
    .fifo_count (fifo_count),
`ifdef AXIS_BURST_TIMEOUT_EN
    .cfg_timeout(cfg_timeout),
`endif
    .sts_data   (sts_data),
    .s_axis     (s_axis),
    .m_axis     (m_axis)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats still owed in the open burst, cycles before the next
  // start decision is allowed, and bursts completed so far.
  int          m_left;
  int          m_cool;
  logic [31:0] m_bursts;
  logic [31:0] m_timer;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_left   <= 0;
      m_cool   <= 0;
      m_bursts <= '0;
      m_timer  <= '0;
    end else if (m_left > 0) begin
      if (s_axis.tvalid && m_axis.tready) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_bursts <= m_bursts + 32'd1;
          m_cool   <= 1;
        end
      end
    end else if (m_cool > 0) begin
      m_cool <= m_cool - 1;
    end else if (cfg_data != 0 && fifo_count >= cfg_data) begin
      m_left  <= int'(cfg_data);
      m_timer <= '0;
    end
`ifdef AXIS_BURST_TIMEOUT_EN
    else if (cfg_timeout != 0 && m_timer >= cfg_timeout && fifo_count != 0 && fifo_count < cfg_data) begin
      m_left  <= int'(fifo_count);
      m_timer <= '0;
    end
`endif
    else if (fifo_count == 0) begin
      m_timer <= '0;
    end else if (fifo_count < cfg_data) begin
      m_timer <= m_timer + 32'd1;
    end
  end

  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_m_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
      chk("rst_m_tlast",  {63'd0, m_axis.tlast},  64'd0);
      chk("rst_s_tready", {63'd0, s_axis.tready}, 64'd0);
      chk("rst_sts",      {32'd0, sts_data},      64'd0);
    end else begin
      chk("m_tvalid", {63'd0, m_axis.tvalid}, {63'd0, (m_left > 0) && s_axis.tvalid});
      chk("s_tready", {63'd0, s_axis.tready}, {63'd0, (m_left > 0) && m_axis.tready});
      chk("m_tlast",  {63'd0, m_axis.tlast},  {63'd0, m_left == 1});
      chk("sts",      {32'd0, sts_data},      {32'd0, m_bursts});
      if (m_axis.tvalid) chk("m_tdata", {32'd0, m_axis.tdata}, {32'd0, s_axis.tdata});
    end
  end

  // Burst statistics seen on the output side.
  int hs_total, tlast_total, beat_in_burst, last_len, gated_run, last_gap;

  always @(negedge aclk) begin
    if (!aresetn) begin
      beat_in_burst = 0;
      gated_run     = 0;
    end else begin
      if (m_axis.tvalid) begin
        if (gated_run > 0) last_gap = gated_run;
        gated_run = 0;
      end else begin
        gated_run++;
      end
      if (m_axis.tvalid && m_axis.tready) begin
        hs_total++;
        beat_in_burst++;
        if (m_axis.tlast) begin
          last_len = beat_in_burst;
          beat_in_burst = 0;
          tlast_total++;
        end
      end
    end
  end

  task automatic clear_stats();
    hs_total = 0; tlast_total = 0; beat_in_burst = 0;
    last_len = 0; gated_run = 0; last_gap = 0;
  endtask

  // FIFO stand-in: level drops by one after each accepted beat.
  int level;
  logic toggle_ready;

  task automatic tick();
    logic hs;
    fifo_count = CW'(level);
    #1;
    hs = m_axis.tvalid && m_axis.tready;
    @(posedge aclk);
    #1;
    if (hs && level > 0) level--;
    fifo_count = CW'(level);
    s_axis.tdata = $urandom;
    if (toggle_ready) m_axis.tready = ~m_axis.tready;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    level = 0;
    repeat (2) tick();
    aresetn = 1'b1;
    clear_stats();
  endtask

  task automatic wait_valid(input int limit);
    int n;
    n = 0;
    while (!m_axis.tvalid && n < limit) begin
      tick();
      n++;
    end
    if (!m_axis.tvalid) begin
      tests++;
      fails++;
      $display("FAIL wait_valid: no m_tvalid within %0d cycles", limit);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    cfg_data = '0;
    fifo_count = '0;
    cfg_timeout = '0;
    s_axis.tdata = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    m_axis.tready = 1'b0;
    toggle_ready = 1'b0;
    level = 0;
    clear_stats();
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_sts", {32'd0, sts_data}, 64'd0);
    chk("reset_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
    aresetn = 1'b1;

    // Threshold: counts below cfg_data keep the stream gated.
    cfg_data = 10'd4;
    s_axis.tvalid = 1'b1;
    m_axis.tready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      level = c;
      tick();
      chk("gate_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
    end
    level = 4;
    tick();
    chk("t1_first_beat", {63'd0, m_axis.tvalid}, 64'd1);
    repeat (8) tick();
    chk("t1_sts", {32'd0, sts_data}, 64'd1);
    chk("t1_len", last_len, 4);
    chk("t1_hs", hs_total, 4);
    chk("t1_tlasts", tlast_total, 1);

    // Backpressure on every other cycle, two full bursts out of 20 words.
    do_reset();
    cfg_data = 10'd8;
    level = 20;
    toggle_ready = 1'b1;
    repeat (60) tick();
    toggle_ready = 1'b0;
    m_axis.tready = 1'b1;
    chk("t2_len", last_len, 8);
    chk("t2_hs", hs_total, 16);
    chk("t2_tlasts", tlast_total, 2);
    chk("t2_gap", last_gap, 2);
    chk("t2_sts", {32'd0, sts_data}, 64'd2);

    // Single-beat bursts.
    do_reset();
    cfg_data = 10'd1;
    level = 3;
    repeat (15) tick();
    chk("t3_sts", {32'd0, sts_data}, 64'd3);
    chk("t3_len", last_len, 1);
    chk("t3_tlasts", tlast_total, 3);
    chk("t3_gap", last_gap, 2);

    // Length change mid-burst takes effect on the next burst only.
    do_reset();
    cfg_data = 10'd4;
    level = 10;
    wait_valid(10);
    cfg_data = 10'd2;
    repeat (4) tick();
    chk("t4_first_len", last_len, 4);
    chk("t4_first_cnt", tlast_total, 1);
    repeat (4) tick();
    chk("t4_second_len", last_len, 2);
    chk("t4_second_cnt", tlast_total, 2);
    repeat (20) tick();
    chk("t4_sts", {32'd0, sts_data}, 64'd4);

    // Reset during beat 2 abandons the burst.
    do_reset();
    cfg_data = 10'd4;
    level = 8;
    wait_valid(10);
    tick();
    chk("t5_beat2_valid", {63'd0, m_axis.tvalid}, 64'd1);
    aresetn = 1'b0;
    #1;
    chk("t5_rst_tvalid", {63'd0, m_axis.tvalid}, 64'd0);
    chk("t5_rst_tlast", {63'd0, m_axis.tlast}, 64'd0);
    chk("t5_rst_sts", {32'd0, sts_data}, 64'd0);
    level = 2;
    repeat (2) tick();
    aresetn = 1'b1;
    clear_stats();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_wait_idle", {63'd0, m_axis.tvalid}, 64'd0);
    end
    level = 4;
    tick();
    chk("t5_restart", {63'd0, m_axis.tvalid}, 64'd1);
    repeat (8) tick();
    chk("t5_sts", {32'd0, sts_data}, 64'd1);
    chk("t5_len", last_len, 4);

`ifdef AXIS_BURST_TIMEOUT_EN
    // Partial fill flushed after the idle timeout.
    do_reset();
    cfg_data = 10'd16;
    cfg_timeout = 32'd10;
    level = 5;
    begin
      int n;
      n = 0;
      while (!m_axis.tvalid && n < 50) begin
        tick();
        n++;
      end
      chk("t6_wait", n, 11);
    end
    repeat (8) tick();
    chk("t6_len", last_len, 5);
    chk("t6_sts", {32'd0, sts_data}, 64'd1);
    cfg_timeout = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
